// File: rtl/cam_pkg.sv
// Symbol codes and state encoding shared by the camera-link pattern source
// and the receive-side alignment logic.
package cam_pkg;

    localparam logic [7:0] SYNC_FS  = 8'hAA;
    localparam logic [7:0] SYNC_LS  = 8'h2A;
    localparam logic [7:0] SYNC_IMG = 8'h0D;
    localparam logic [7:0] SYNC_LE  = 8'h4A;
    localparam logic [7:0] SYNC_FE  = 8'hCA;
    localparam logic [7:0] SYNC_BL  = 8'h15;
    localparam logic [7:0] TRAIN    = 8'h3A;

    localparam logic [7:0]  CONST_LANE = 8'hA5;
    localparam logic [31:0] TRAIN_DATA = {4{TRAIN}};
    localparam logic [39:0] IDLE_WORD  = {SYNC_BL, TRAIN_DATA};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LINE,
        ST_HBLANK,
        ST_VBLANK
    } cam_state_t;

    // Lane i carries base + i; concatenation operands stay 8 bits, so each lane wraps mod 256.
    function automatic logic [31:0] ramp_data(input logic [7:0] base);
        return {base + 8'd3, base + 8'd2, base + 8'd1, base};
    endfunction

endpackage

// File: rtl/cam_pattern_tx.sv
// Camera-link test pattern source: emits framed 40-bit symbol words
// ({sync, d3, d2, d1, d0}) in the same format as the deserializer output.
module cam_pattern_tx
    import cam_pkg::*;
#(
    parameter int DW = 40
) (
    input  logic          clk125,
    input  logic          rst_n,
    input  logic          start,
    input  logic          continuous,
    input  logic          invert,
    input  logic          pattern_sel,
    input  logic [11:0]   cfg_width,
    input  logic [11:0]   cfg_height,
    input  logic [7:0]    cfg_hblank,
    input  logic [15:0]   cfg_vblank,
    output logic [DW-1:0] rxd,
    output logic          busy,
    output logic          frame_done
);

    cam_state_t  state;
    logic [11:0] kcnt;
    logic [11:0] lcnt;
    logic [15:0] bcnt;
    logic [7:0]  base;

    logic [11:0] w_q;
    logic [11:0] h_q;
    logic [7:0]  hb_q;
    logic [15:0] vb_q;
    logic        inv_q;

    logic [11:0] w_clamp;
    logic [11:0] h_clamp;
    logic [7:0]  hb_clamp;
    logic [15:0] vb_clamp;
    logic        last_kernel;
    logic        last_line;
    logic        hb_done;
    logic        vb_done;
    logic        launch;
    logic [7:0]  next_sync;

    function automatic logic [31:0] line_data(input logic [7:0] b, input logic const_sel);
        return const_sel ? {4{CONST_LANE}} : ramp_data(b);
    endfunction

    function automatic logic [39:0] make_word(input logic [7:0] sync, input logic [31:0] data,
                                              input logic inv);
        return {sync, data ^ {32{inv}}};
    endfunction

    always_comb begin
        w_clamp     = (cfg_width < 12'd2) ? 12'd2 : cfg_width;
        h_clamp     = (cfg_height == 12'd0) ? 12'd1 : cfg_height;
        hb_clamp    = (cfg_hblank == 8'd0) ? 8'd1 : cfg_hblank;
        vb_clamp    = (cfg_vblank == 16'd0) ? 16'd1 : cfg_vblank;
        last_kernel = (kcnt == w_q - 12'd1);
        last_line   = (lcnt == h_q - 12'd1);
        hb_done     = (bcnt == 16'(hb_q) - 16'd1);
        vb_done     = (bcnt == vb_q - 16'd1);
        // A new frame starts from IDLE on start, or back-to-back when continuous at vblank end.
        launch      = ((state == ST_IDLE) && start) ||
                      ((state == ST_VBLANK) && vb_done && continuous);
        // Sync code for the kernel entered on the next edge while staying in LINE.
        next_sync   = SYNC_IMG;
        if (kcnt + 12'd1 == w_q - 12'd1) begin
            next_sync = last_line ? SYNC_FE : SYNC_LE;
        end
    end

    assign busy = (state != ST_IDLE);

    // NOTE: every state and output register uses non-blocking assignment and is cleared by
    // the async reset, so the word on rxd always matches the state entered on the same edge.
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            kcnt       <= '0;
            lcnt       <= '0;
            bcnt       <= '0;
            base       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            hb_q       <= '0;
            vb_q       <= '0;
            inv_q      <= 1'b0;
            rxd        <= IDLE_WORD;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (launch) begin
                state <= ST_LINE;
                kcnt  <= '0;
                lcnt  <= '0;
                bcnt  <= '0;
                base  <= 8'd4;
                w_q   <= w_clamp;
                h_q   <= h_clamp;
                hb_q  <= hb_clamp;
                vb_q  <= vb_clamp;
                inv_q <= invert;
                rxd   <= make_word(SYNC_FS, line_data(8'd0, pattern_sel), invert);
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        rxd <= IDLE_WORD;
                    end
                    ST_LINE: begin
                        if (last_kernel) begin
                            bcnt <= '0;
                            rxd  <= make_word(SYNC_BL, TRAIN_DATA, inv_q);
                            if (last_line) begin
                                state      <= ST_VBLANK;
                                frame_done <= (vb_q == 16'd1);
                            end else begin
                                state <= ST_HBLANK;
                            end
                        end else begin
                            kcnt <= kcnt + 12'd1;
                            base <= base + 8'd4;
                            rxd  <= make_word(next_sync, line_data(base, pattern_sel), inv_q);
                        end
                    end
                    ST_HBLANK: begin
                        if (hb_done) begin
                            state <= ST_LINE;
                            kcnt  <= '0;
                            lcnt  <= lcnt + 12'd1;
                            base  <= base + 8'd4;
                            rxd   <= make_word(SYNC_LS, line_data(base, pattern_sel), inv_q);
                        end else begin
                            bcnt <= bcnt + 16'd1;
                        end
                    end
                    ST_VBLANK: begin
                        if (vb_done) begin
                            state <= ST_IDLE;
                            rxd   <= IDLE_WORD;
                        end else begin
                            bcnt       <= bcnt + 16'd1;
                            frame_done <= (bcnt + 16'd1 == vb_q - 16'd1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        rxd   <= IDLE_WORD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cam_pattern_tx.sv
// Scoreboard bench for cam_pattern_tx: a frame model queues the expected
// {rxd, frame_done, busy} per cycle, and a monitor pops and compares after each edge.
module tb_cam_pattern_tx;

    localparam logic [39:0] IDLE_W = 40'h15_3A3A3A3A;

    logic        clk125      = 1'b0;
    logic        rst_n       = 1'b0;
    logic        start       = 1'b0;
    logic        continuous  = 1'b0;
    logic        invert      = 1'b0;
    logic        pattern_sel = 1'b0;
    logic [11:0] cfg_width   = 12'd4;
    logic [11:0] cfg_height  = 12'd2;
    logic [7:0]  cfg_hblank  = 8'd2;
    logic [15:0] cfg_vblank  = 16'd3;
    logic [39:0] rxd;
    logic        busy;
    logic        frame_done;

    typedef struct packed {
        logic [39:0] word;
        logic        fd;
        logic        bsy;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   mon_en = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    cam_pattern_tx #(.DW(40)) dut (
        .clk125      (clk125),
        .rst_n       (rst_n),
        .start       (start),
        .continuous  (continuous),
        .invert      (invert),
        .pattern_sel (pattern_sel),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .cfg_hblank  (cfg_hblank),
        .cfg_vblank  (cfg_vblank),
        .rxd         (rxd),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #4 clk125 = ~clk125;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk125) begin
        #1;
        if (mon_en && sb.size() > 0) begin
            cur = sb.pop_front();
            check("rxd", rxd, cur.word);
            check("frame_done", 40'(frame_done), 40'(cur.fd));
            check("busy", 40'(busy), 40'(cur.bsy));
        end
    end

    task automatic push_idle();
        sb.push_back('{word: IDLE_W, fd: 1'b0, bsy: 1'b0});
    endtask

    // Reference frame built straight from the line/blank timing rules.
    task automatic push_frame(input int w, input int h, input int hb, input int vb,
                              input bit inv, input bit pat);
        logic [7:0]  b;
        logic [7:0]  s;
        logic [31:0] d;
        logic [31:0] tm;
        int wc;
        int hc;
        int hbc;
        int vbc;
        b   = 8'd0;
        tm  = inv ? 32'hFFFF_FFFF : 32'h0;
        wc  = (w < 2) ? 2 : w;
        hc  = (h == 0) ? 1 : h;
        hbc = (hb == 0) ? 1 : hb;
        vbc = (vb == 0) ? 1 : vb;
        for (int l = 0; l < hc; l++) begin
            for (int k = 0; k < wc; k++) begin
                if (k == 0)           s = (l == 0) ? 8'hAA : 8'h2A;
                else if (k == wc - 1) s = (l == hc - 1) ? 8'hCA : 8'h4A;
                else                  s = 8'h0D;
                for (int i = 0; i < 4; i++) d[8*i +: 8] = pat ? 8'hA5 : b + 8'(i);
                b = b + 8'd4;
                sb.push_back('{word: {s, d ^ tm}, fd: 1'b0, bsy: 1'b1});
            end
            if (l < hc - 1) begin
                for (int j = 0; j < hbc; j++)
                    sb.push_back('{word: {8'h15, 32'h3A3A3A3A ^ tm}, fd: 1'b0, bsy: 1'b1});
            end
        end
        for (int j = 0; j < vbc; j++)
            sb.push_back('{word: {8'h15, 32'h3A3A3A3A ^ tm}, fd: (j == vbc - 1), bsy: 1'b1});
    endtask

    task automatic launch(input int w, input int h, input int hb, input int vb,
                          input bit inv, input bit pat, input bit cont);
        @(negedge clk125);
        cfg_width   = 12'(w);
        cfg_height  = 12'(h);
        cfg_hblank  = 8'(hb);
        cfg_vblank  = 16'(vb);
        invert      = inv;
        pattern_sel = pat;
        continuous  = cont;
        start       = 1'b1;
        push_frame(w, h, hb, vb, inv, pat);
        if (!cont) push_idle();
        mon_en = 1'b1;
        @(negedge clk125);
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sb.size() > 0 && t < 3000) begin
            @(negedge clk125);
            t++;
        end
        check(tag, 40'(sb.size()), 40'd0);
    endtask

    initial begin
        int t;
        #20;
        check("reset_rxd", rxd, IDLE_W);
        check("reset_busy", 40'(busy), 40'd0);
        check("reset_fd", 40'(frame_done), 40'd0);
        @(negedge clk125);
        rst_n = 1'b1;
        repeat (3) @(negedge clk125);
        check("idle_no_start", rxd, IDLE_W);

        // Basic ramp frame, then the same frame inverted.
        launch(4, 2, 2, 3, 1'b0, 1'b0, 1'b0);
        drain("drain_ramp");
        launch(4, 2, 2, 3, 1'b1, 1'b0, 1'b0);
        drain("drain_invert");

        // Constant pattern; config, invert and start toggled while busy must not matter.
        launch(5, 3, 3, 2, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk125);
        cfg_width  = 12'd9;
        cfg_hblank = 8'd7;
        invert     = 1'b1;
        start      = 1'b1;
        @(negedge clk125);
        start = 1'b0;
        repeat (10) @(negedge clk125);
        start = 1'b1;
        @(negedge clk125);
        start = 1'b0;
        drain("drain_busy_ignore");

        // Degenerate config clamps: width 0, height 0, zero blanking.
        launch(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        drain("drain_clamp");
        launch(1, 3, 0, 1, 1'b1, 1'b0, 1'b0);
        drain("drain_clamp2");

        // Continuous back-to-back frames with ramp wrap.
        launch(64, 2, 2, 3, 1'b0, 1'b0, 1'b1);
        push_frame(64, 2, 2, 3, 1'b0, 1'b0);
        push_idle();
        t = 0;
        while (sb.size() > 133 && t < 3000) begin
            @(negedge clk125);
            t++;
        end
        continuous = 1'b0;
        drain("drain_continuous");

        // Reset asserted in the middle of a line.
        launch(20, 2, 2, 2, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk125);
        rst_n  = 1'b0;
        mon_en = 1'b0;
        sb.delete();
        #1;
        check("midreset_rxd", rxd, IDLE_W);
        check("midreset_busy", 40'(busy), 40'd0);
        check("midreset_fd", 40'(frame_done), 40'd0);
        repeat (2) @(negedge clk125);
        rst_n = 1'b1;
        repeat (6) @(negedge clk125);
        check("post_reset_rxd", rxd, IDLE_W);
        check("post_reset_busy", 40'(busy), 40'd0);

        launch(3, 1, 1, 2, 1'b0, 1'b0, 1'b0);
        drain("drain_recover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
